// File: rtl/alu_muldiv.sv
// Iterative RISC-V M-extension multiply/divide unit with fixed W+2 cycle latency.
// Magnitudes are processed radix-2; signs and special cases are applied in FIX.
module alu_muldiv #(
  parameter int W = 32,
  localparam int CNT_W = $clog2(W)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic         kill,
  input  logic [2:0]   fn,
  input  logic [W-1:0] x,
  input  logic [W-1:0] y,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] out,
  output logic         zero
);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX} state_t;

  state_t           state;
  logic [2:0]       fn_q;
  logic [W-1:0]     x_q;
  logic [W-1:0]     opd;
  logic [W-1:0]     hi;
  logic [W-1:0]     lo;
  logic [CNT_W-1:0] cnt;
  logic             neg_q;
  logic             div_zero_q;
  logic             ovf_q;
  logic [W-1:0]     out_q;
  logic             zero_q;
  logic             done_q;

  logic             is_div;
  logic             x_signed;
  logic             y_signed;
  logic             x_neg;
  logic             y_neg;
  logic [W-1:0]     x_abs;
  logic [W-1:0]     y_abs;
  logic             neg_d;
  logic             div_zero_d;
  logic             ovf_d;

  // Operand decode at issue: signedness per funct3, magnitudes, result sign
  always_comb begin
    is_div     = fn[2];
    x_signed   = is_div ? ~fn[0] : (fn[1:0] == 2'd1 || fn[1:0] == 2'd2);
    y_signed   = is_div ? ~fn[0] : (fn[1:0] == 2'd1);
    x_neg      = x_signed & x[W-1];
    y_neg      = y_signed & y[W-1];
    x_abs      = x_neg ? -x : x;
    y_abs      = y_neg ? -y : y;
    neg_d      = (is_div && fn[1]) ? x_neg : (x_neg ^ y_neg);
    div_zero_d = is_div && (y == '0);
    ovf_d      = is_div && !fn[0] && (x == {1'b1, {(W-1){1'b0}}}) && (y == '1);
  end

  logic [W:0] mul_sum;
  logic [W:0] div_shift;
  logic [W:0] div_diff;
  logic       div_ge;

  // One radix-2 step: shift-add for multiply, restoring subtract for divide
  always_comb begin
    mul_sum   = {1'b0, hi} + (lo[0] ? {1'b0, opd} : '0);
    div_shift = {hi, lo[W-1]};
    div_diff  = div_shift - {1'b0, opd};
    div_ge    = ~div_diff[W];
  end

  logic [2*W-1:0] prod_s;
  logic [W-1:0]   quo_s;
  logic [W-1:0]   rem_s;
  logic [W-1:0]   result;

  // After W steps hi:lo is the magnitude product, or remainder:quotient for divide
  always_comb begin
    prod_s = neg_q ? -{hi, lo} : {hi, lo};
    quo_s  = neg_q ? -lo : lo;
    rem_s  = neg_q ? -hi : hi;
    result = '0;
    if (!fn_q[2]) begin
      result = (fn_q[1:0] == 2'd0) ? prod_s[W-1:0] : prod_s[2*W-1:W];
    end else if (!fn_q[1]) begin
      result = div_zero_q ? '1 : (ovf_q ? x_q : quo_s);
    end else begin
      result = div_zero_q ? x_q : (ovf_q ? '0 : rem_s);
    end
  end

  // Control FSM and datapath registers; kill overrides every state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      fn_q       <= '0;
      x_q        <= '0;
      opd        <= '0;
      hi         <= '0;
      lo         <= '0;
      cnt        <= '0;
      neg_q      <= 1'b0;
      div_zero_q <= 1'b0;
      ovf_q      <= 1'b0;
      out_q      <= '0;
      zero_q     <= 1'b1;
      done_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (kill) begin
        state <= S_IDLE;
      end else begin
        case (state)
          S_IDLE: begin
            if (start) begin
              state      <= S_CALC;
              fn_q       <= fn;
              x_q        <= x;
              cnt        <= '0;
              hi         <= '0;
              neg_q      <= neg_d;
              div_zero_q <= div_zero_d;
              ovf_q      <= ovf_d;
              if (is_div) begin
                opd <= y_abs;
                lo  <= x_abs;
              end else begin
                opd <= x_abs;
                lo  <= y_abs;
              end
            end
          end
          S_CALC: begin
            if (fn_q[2]) begin
              hi <= div_ge ? div_diff[W-1:0] : div_shift[W-1:0];
              lo <= {lo[W-2:0], div_ge};
            end else begin
              hi <= mul_sum[W:1];
              lo <= {mul_sum[0], lo[W-1:1]};
            end
            cnt <= cnt + CNT_W'(1);
            if (cnt == CNT_W'(W-1)) begin
              state <= S_FIX;
            end
          end
          S_FIX: begin
            out_q  <= result;
            zero_q <= (result == '0);
            done_q <= 1'b1;
            state  <= S_IDLE;
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

  assign busy = (state != S_IDLE);
  assign done = done_q;
  assign out  = out_q;
  assign zero = zero_q;

endmodule

// File: tb/tb_alu_muldiv.sv
// Scoreboard bench for alu_muldiv: directed vectors at W=32 and W=8,
// plus kill, ignored-start, back-to-back and asynchronous reset scenarios.
module tb_alu_muldiv;

  typedef struct {
    logic [31:0] val;
    int          cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;

  logic        start32 = 1'b0;
  logic        kill32 = 1'b0;
  logic [2:0]  fn32 = '0;
  logic [31:0] x32 = '0;
  logic [31:0] y32 = '0;
  logic        busy32;
  logic        done32;
  logic [31:0] out32;
  logic        zero32;

  logic        start8 = 1'b0;
  logic        kill8 = 1'b0;
  logic [2:0]  fn8 = '0;
  logic [7:0]  x8 = '0;
  logic [7:0]  y8 = '0;
  logic        busy8;
  logic        done8;
  logic [7:0]  out8;
  logic        zero8;

  int          cyc = 0;
  int          n_checks = 0;
  int          n_fail = 0;
  exp_t        sb32[$];
  exp_t        sb8[$];

  alu_muldiv #(.W(32)) dut32 (
    .clk(clk), .rst_n(rst_n), .start(start32), .kill(kill32), .fn(fn32),
    .x(x32), .y(y32), .busy(busy32), .done(done32), .out(out32), .zero(zero32)
  );

  alu_muldiv #(.W(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .kill(kill8), .fn(fn8),
    .x(x8), .y(y8), .busy(busy8), .done(done8), .out(out8), .zero(zero8)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  task automatic waitCycle(input int t);
    while (cyc < t) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic applyStimulus(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                               input logic [31:0] expv, input bit push, output int s);
    exp_t e;
    fn32    = f;
    x32     = a;
    y32     = b;
    start32 = 1'b1;
    s       = cyc;
    if (push) begin
      e.val = expv;
      e.cyc = s + 34;
      sb32.push_back(e);
    end
    @(posedge clk);
    #1;
    start32 = 1'b0;
    checkOutput("busy_after_start32", {31'b0, busy32}, 32'd1);
  endtask

  task automatic applyStimulus8(input logic [2:0] f, input logic [7:0] a, input logic [7:0] b,
                                input logic [7:0] expv, output int s);
    exp_t e;
    fn8    = f;
    x8     = a;
    y8     = b;
    start8 = 1'b1;
    s      = cyc;
    e.val  = {24'b0, expv};
    e.cyc  = s + 10;
    sb8.push_back(e);
    @(posedge clk);
    #1;
    start8 = 1'b0;
    checkOutput("busy_after_start8", {31'b0, busy8}, 32'd1);
  endtask

  // Monitor: every done strobe must match the oldest outstanding expectation
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && done32) begin
      if (sb32.size() == 0) begin
        checkOutput("unexpected_done32", {31'b0, done32}, 32'd0);
      end else begin
        e = sb32.pop_front();
        checkOutput("out32", out32, e.val);
        checkOutput("zero32", {31'b0, zero32}, {31'b0, (e.val == 32'd0)});
        checkOutput("done_cycle32", cyc, e.cyc);
        checkOutput("busy_at_done32", {31'b0, busy32}, 32'd0);
      end
    end
    if (rst_n && done8) begin
      if (sb8.size() == 0) begin
        checkOutput("unexpected_done8", {31'b0, done8}, 32'd0);
      end else begin
        e = sb8.pop_front();
        checkOutput("out8", {24'b0, out8}, e.val);
        checkOutput("zero8", {31'b0, zero8}, {31'b0, (e.val == 32'd0)});
        checkOutput("done_cycle8", cyc, e.cyc);
        checkOutput("busy_at_done8", {31'b0, busy8}, 32'd0);
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [2:0]  v_fn [21];
    logic [31:0] v_x  [21];
    logic [31:0] v_y  [21];
    logic [31:0] v_e  [21];
    logic [2:0]  w_fn [7];
    logic [7:0]  w_x  [7];
    logic [7:0]  w_y  [7];
    logic [7:0]  w_e  [7];
    int          s;
    int          guard;
    exp_t        e;

    v_fn = '{3'd0, 3'd1, 3'd3, 3'd2, 3'd3, 3'd4, 3'd6, 3'd5, 3'd7, 3'd5, 3'd6,
             3'd4, 3'd6, 3'd4, 3'd6, 3'd4, 3'd6, 3'd1, 3'd0, 3'd5, 3'd7};
    v_x  = '{32'd7, 32'h80000000, 32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF,
             32'hFFFFFFF9, 32'hFFFFFFF9, 32'd100, 32'd100, 32'd5, 32'd5,
             32'h80000000, 32'h80000000, 32'd7, 32'd7, 32'hFFFFFFFB, 32'hFFFFFFFB,
             32'hFFFFFFFD, 32'h12345678, 32'h80000000, 32'h80000000};
    v_y  = '{32'hFFFFFFFD, 32'h80000000, 32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF,
             32'd2, 32'd2, 32'd7, 32'd7, 32'd0, 32'd0,
             32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'hFFFFFFFE, 32'd0, 32'd0,
             32'd7, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFF};
    v_e  = '{32'hFFFFFFEB, 32'h40000000, 32'h40000000, 32'hFFFFFFFF, 32'hFFFFFFFE,
             32'hFFFFFFFD, 32'hFFFFFFFF, 32'd14, 32'd2, 32'hFFFFFFFF, 32'd5,
             32'h80000000, 32'd0, 32'hFFFFFFFD, 32'd1, 32'hFFFFFFFF, 32'hFFFFFFFB,
             32'hFFFFFFFF, 32'd0, 32'd0, 32'h80000000};

    w_fn = '{3'd0, 3'd4, 3'd6, 3'd4, 3'd6, 3'd1, 3'd5};
    w_x  = '{8'h07, 8'hF9, 8'hF9, 8'h80, 8'h80, 8'h80, 8'h05};
    w_y  = '{8'hFD, 8'h02, 8'h02, 8'hFF, 8'hFF, 8'h80, 8'h00};
    w_e  = '{8'hEB, 8'hFD, 8'hFF, 8'h80, 8'h00, 8'h40, 8'hFF};

    $display("[TB] reset phase");
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_busy32", {31'b0, busy32}, 32'd0);
    checkOutput("reset_done32", {31'b0, done32}, 32'd0);
    checkOutput("reset_out32", out32, 32'd0);
    checkOutput("reset_zero32", {31'b0, zero32}, 32'd1);
    checkOutput("reset_out8", {24'b0, out8}, 32'd0);
    checkOutput("reset_zero8", {31'b0, zero8}, 32'd1);
    #2;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    $display("[TB] W=32 directed vectors, issued back-to-back in each done cycle");
    for (int i = 0; i < 21; i++) begin
      applyStimulus(v_fn[i], v_x[i], v_y[i], v_e[i], 1'b1, s);
      waitCycle(s + 34);
    end
    waitCycle(s + 36);

    $display("[TB] kill mid-operation");
    applyStimulus(3'd0, 32'd7, 32'd3, 32'd0, 1'b0, s);
    waitCycle(s + 10);
    kill32 = 1'b1;
    @(posedge clk);
    #1;
    kill32 = 1'b0;
    checkOutput("busy_after_kill", {31'b0, busy32}, 32'd0);
    waitCycle(s + 45);
    checkOutput("out_held_after_kill", out32, 32'h80000000);
    checkOutput("zero_held_after_kill", {31'b0, zero32}, 32'd0);

    $display("[TB] kill together with start");
    fn32 = 3'd0; x32 = 32'd5; y32 = 32'd5;
    start32 = 1'b1;
    kill32 = 1'b1;
    s = cyc;
    @(posedge clk);
    #1;
    start32 = 1'b0;
    kill32 = 1'b0;
    checkOutput("kill_beats_start", {31'b0, busy32}, 32'd0);
    waitCycle(s + 40);
    checkOutput("out_held_after_kill_start", out32, 32'h80000000);

    $display("[TB] start while busy is ignored");
    applyStimulus(3'd5, 32'd100, 32'd7, 32'd14, 1'b1, s);
    waitCycle(s + 5);
    fn32 = 3'd0; x32 = 32'd3; y32 = 32'd3;
    start32 = 1'b1;
    @(posedge clk);
    #1;
    start32 = 1'b0;
    checkOutput("busy_ignored_start", {31'b0, busy32}, 32'd1);
    waitCycle(s + 40);

    $display("[TB] asynchronous reset mid-calculation");
    applyStimulus(3'd0, 32'd7, 32'd3, 32'd0, 1'b0, s);
    waitCycle(s + 8);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("async_reset_busy", {31'b0, busy32}, 32'd0);
    checkOutput("async_reset_done", {31'b0, done32}, 32'd0);
    checkOutput("async_reset_out", out32, 32'd0);
    checkOutput("async_reset_zero", {31'b0, zero32}, 32'd1);
    #3;
    rst_n = 1'b1;
    waitCycle(s + 45);

    $display("[TB] W=8 directed vectors");
    for (int i = 0; i < 7; i++) begin
      applyStimulus8(w_fn[i], w_x[i], w_y[i], w_e[i], s);
      waitCycle(s + 10);
    end

    guard = 0;
    while ((sb32.size() != 0 || sb8.size() != 0) && guard < 100) begin
      @(posedge clk);
      #1;
      guard++;
    end
    while (sb32.size() != 0) begin
      e = sb32.pop_front();
      n_checks++;
      n_fail++;
      $display("[TB] FAIL missing_done32: no done seen, expected out 0x%08h at cycle %0d", e.val, e.cyc);
    end
    while (sb8.size() != 0) begin
      e = sb8.pop_front();
      n_checks++;
      n_fail++;
      $display("[TB] FAIL missing_done8: no done seen, expected out 0x%08h at cycle %0d", e.val, e.cyc);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
